// File: rtl/arb_pkg.sv
// Shared types and helpers for the 8-requester round-robin arbiter.
package arb_pkg;
  localparam int N   = 8;
  localparam int IDW = 3;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  function automatic logic [N-1:0] onehot8(input logic [IDW-1:0] idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/rr_pick_8.sv
// Rotated priority encoder: descending search from start, wrapping 0->7.
module rr_pick_8
  import arb_pkg::*;
(
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  input  logic [IDW-1:0] start,
  output logic [IDW-1:0] win_id,
  output logic           win_valid
);
  logic [N-1:0]   w_eff;
  logic [IDW-1:0] w_idx;

  assign w_eff = req & ~mask;

  // Walk from farthest to nearest so the slot at start is written last and wins.
  always_comb begin
    win_id    = '0;
    win_valid = 1'b0;
    w_idx     = '0;
    for (int k = N-1; k >= 0; k--) begin
      w_idx = start - IDW'(k);
      if (w_eff[w_idx]) begin
        win_id    = w_idx;
        win_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester arbiter with registered one-hot grant, rotation and hold timeout.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           rr_mode,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);
  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_t     r_state;
  logic [N-1:0]   r_gnt;
  logic [IDW-1:0] r_gnt_id;
  logic [IDW-1:0] r_last_id;
  logic [HW-1:0]  r_hold;
  logic           r_timeout;

  logic [IDW-1:0] w_start;
  logic [N-1:0]   w_mask;
  logic [IDW-1:0] w_win_id;
  logic           w_win_valid;
  logic           w_own;
  logic           w_to;

  // Fixed mode pins the search start at 7 regardless of history.
  assign w_start = rr_mode ? (r_last_id - 1'b1) : IDW'(N-1);
  assign w_mask  = (r_state == GRANT) ? onehot8(r_gnt_id) : '0;
  assign w_own   = req[r_gnt_id];
  assign w_to    = (MAX_HOLD != 0) && (r_state == GRANT) && w_own && (r_hold == HOLD_LAST);

  rr_pick_8 u_pick (
    .req       (req),
    .mask      (w_mask),
    .start     (w_start),
    .win_id    (w_win_id),
    .win_valid (w_win_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_last_id <= '0;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_win_valid) begin
            r_state   <= GRANT;
            r_gnt     <= onehot8(w_win_id);
            r_gnt_id  <= w_win_id;
            r_last_id <= w_win_id;
            r_hold    <= '0;
          end
        end
        GRANT: begin
          if (w_own && !w_to) begin
            if (r_hold != '1) r_hold <= r_hold + 1'b1;
          end else begin
            r_timeout <= w_to;
            r_hold    <= '0;
            if (w_win_valid) begin
              r_gnt     <= onehot8(w_win_id);
              r_gnt_id  <= w_win_id;
              r_last_id <= w_win_id;
            end else if (!w_to) begin
              r_state <= IDLE;
              r_gnt   <= '0;
            end
            // Timeout with no contender: keep the same grant, counter restarts.
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = |r_gnt;
  assign timeout   = r_timeout;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: reset, rotation, fixed mode, timeout, mid-grant reset.
module tb_rr_arbiter_8;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       rr_mode;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.MAX_HOLD(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rr_mode   (rr_mode),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_gnt(input string tag, input logic [2:0] id, input logic to);
    logic [7:0] oh;
    oh = 8'h01 << id;
    chk({tag, "_gnt"}, gnt, oh);
    chk({tag, "_id"}, gnt_id, id);
    chk({tag, "_vld"}, gnt_valid, 1'b1);
    chk({tag, "_to"}, timeout, to);
  endtask

  initial begin
    logic [2:0] cur;
    rst = 1'b1; req = 8'hFF; rr_mode = 1'b1;
    step(); step();
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_vld", gnt_valid, 1'b0);
    chk("rst_id",  gnt_id, 3'd0);
    chk("rst_to",  timeout, 1'b0);

    rst = 1'b0;
    step();
    chk_gnt("first", 3'd7, 1'b0);

    // Rotation: each owner holds 3 cycles, drops req for one cycle.
    cur = 3'd7;
    for (int i = 0; i < 8; i++) begin
      chk_gnt("rot_c1", cur, 1'b0);
      step(); chk_gnt("rot_c2", cur, 1'b0);
      step(); chk_gnt("rot_c3", cur, 1'b0);
      req = 8'hFF & ~(8'h01 << cur);
      step();
      req = 8'hFF;
      cur = cur - 3'd1;
    end
    chk_gnt("rot_wrap", 3'd7, 1'b0);

    // Fixed priority.
    rr_mode = 1'b0; req = 8'b0010_0100;
    step(); chk_gnt("fix_5", 3'd5, 1'b0);
    req = 8'b0000_0100;
    step(); chk_gnt("fix_2", 3'd2, 1'b0);
    req = 8'h00;
    step();
    chk("fix_idle_gnt", gnt, 8'h00);
    chk("fix_idle_vld", gnt_valid, 1'b0);
    chk("fix_idle_id",  gnt_id, 3'd2);
    req = 8'b0010_0100;
    step(); chk_gnt("fix_5b", 3'd5, 1'b0);
    req = 8'h00;
    step(); chk("fix_rel", gnt, 8'h00);

    // Timeout between two contenders.
    rr_mode = 1'b1; req = 8'b0000_0011;
    step();
    for (int c = 0; c < 16; c++) begin
      chk_gnt("to_r1", 3'd1, 1'b0);
      step();
    end
    chk_gnt("to_sw0", 3'd0, 1'b1);
    for (int c = 1; c < 16; c++) begin
      step(); chk_gnt("to_r0", 3'd0, 1'b0);
    end
    step(); chk_gnt("to_sw1", 3'd1, 1'b1);

    // Sole requester: regranted with pulse, no drop.
    req = 8'h08;
    step(); chk_gnt("sole_start", 3'd3, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int c = 1; c < 16; c++) begin
        step(); chk_gnt("sole_hold", 3'd3, 1'b0);
      end
      step(); chk_gnt("sole_to", 3'd3, 1'b1);
    end

    // Mid-grant reset.
    req = 8'h10;
    step(); chk_gnt("mr_4", 3'd4, 1'b0);
    step(); chk_gnt("mr_4b", 3'd4, 1'b0);
    rst = 1'b1;
    step();
    chk("mr_rst_gnt", gnt, 8'h00);
    chk("mr_rst_id",  gnt_id, 3'd0);
    chk("mr_rst_vld", gnt_valid, 1'b0);
    chk("mr_rst_to",  timeout, 1'b0);
    rst = 1'b0;
    step(); chk_gnt("mr_after", 3'd4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Eight-requester arbiter that shares one resource using registered grants.
- Winner selection is a rotating 8-to-3 priority encode. With rr_mode=0 it degenerates to the team's fixed priority order: bit 7 highest, bit 0 lowest.
- Sits in front of any shared datapath port (bus master, shared ALU). Requesters hold req high for the whole transaction and drop it to release.
- An optional hold timeout stops one requester from starving the others.

Parameters:
- N, 8, number of requesters; this revision supports 8 only.
- IDW, 3, grant index width, equal to $clog2(N).
- MAX_HOLD, 16, maximum consecutive grant cycles before forced re-arbitration; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req  input  8  request vector; bit i belongs to requester i
- rr_mode  input  1  1 = round-robin rotation; 0 = fixed priority (7 highest)
- gnt  output  8  one-hot grant, registered
- gnt_id  output  3  binary index of the granted requester, registered
- gnt_valid  output  1  high when exactly one gnt bit is set; always equals |gnt
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Reset is synchronous. rst=1 at a clock edge gives state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, timeout=0, last_id=0, hold_cnt=0. Reset overrides everything, including a grant in progress.
- Search order is descending index, starting at (last_id-1) mod 8 and wrapping 0->7. With rr_mode=0, last_id is treated as 0, so the search starts at 7.
- After reset last_id=0, so the first arbitration matches the fixed-priority order.
- State IDLE:
  - If |req, the winner is registered at the next edge: gnt=onehot(w), gnt_id=w, last_id=w, hold_cnt=0, state=GRANT.
  - Latency from req assertion to gnt is 1 cycle.
  - If req==0, the arbiter stays in IDLE with gnt=0.
- State GRANT, hold case: while req[gnt_id]=1 and no timeout, the grant is held and hold_cnt increments.
  - hold_cnt has width $clog2(MAX_HOLD)+1 and saturates.
  - Changes on other req bits are ignored.
- State GRANT, voluntary release (req[gnt_id]=0 sampled):
  - Re-arbitrate in the same edge over req with bit gnt_id masked.
  - If a winner exists, grant it back-to-back with no idle bubble; otherwise go to IDLE with gnt=0.
- State GRANT, timeout (MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, req[gnt_id]=1):
  - timeout pulses for one cycle, aligned with the new grant.
  - Re-arbitrate with bit gnt_id masked.
  - If no other request is pending, the same requester is regranted and hold_cnt is cleared.
- Grant length is therefore at most MAX_HOLD cycles while contended.
- gnt is always zero or one-hot. gnt_id holds its last value while gnt=0.
- A change to rr_mode takes effect at the next arbitration event. It never revokes an active grant.

Decomposition:
- Shared package arb_pkg holds:
  - localparams N=8 and IDW=3
  - typedef enum logic {IDLE, GRANT} arb_state_t
  - function onehot8(idx)
- Sub-module rr_pick_8 is combinational and holds no state.
  - Inputs: req[7:0], mask[7:0], start[2:0].
  - Outputs: win_id[2:0], win_valid.
  - It implements the rotated priority encoder: descending search from start, wrapping.
- The top level holds the FSM, hold counter, last_id register and output registers.

Test Plan:
1. Reset and priority: rst=1 for 2 cycles with req=8'hFF -> gnt=0, gnt_valid=0, gnt_id=0. Release rst with rr_mode=1 -> next cycle gnt=8'h80, gnt_id=7.
2. Rotation: req=8'hFF held. Each grant owner drops its req for one cycle after 3 cycles of grant -> grant sequence 7,6,5,...,0,7 with no idle cycle between grants.
3. Fixed mode: rr_mode=0, req=8'b0010_0100 -> gnt_id=5. Requester 5 releases -> gnt_id=2. Requester 2 releases, then req=8'b0010_0100 again -> gnt_id=5, not 2.
4. Timeout: MAX_HOLD=16, req=8'b0000_0011 held -> gnt_id=1 for exactly 16 cycles. Then timeout=1 for one cycle, gnt_id=0 for 16 cycles, then gnt_id=1.
5. Sole requester timeout: req=8'h08 held -> timeout pulses every 16 cycles, gnt stays 8'h08 continuously with no drop.
6. Mid-grant reset: gnt_id=4 active, assert rst for 1 cycle -> gnt=0 at that edge. After rst is released with req=8'h10, gnt_id=4 again after 1 cycle, since last_id was reset to 0.
